// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and clock-rate constants for the key debouncer.
package key_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_LOCK   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_LOCK = 2'd3
  } state_t;
  localparam logic [15:0] T1MS_50MHZ = 16'd49_999;
endpackage

// File: rtl/key_debounce_ctrl_ms_tick_gen.sv
// ms_tick_gen: prescaler counting 0..T1MS with synchronous clear; tick while at T1MS.
module ms_tick_gen
  import key_pkg::*;
#(
  parameter logic [15:0] T1MS = T1MS_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == T1MS;
    cnt_d = (clr || tick) ? 16'd0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: turns edge-detector pulses into debounced press/release/long-press
// events with a ms lockout and a pin re-check when each lockout expires.
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter logic [15:0] T1MS        = T1MS_50MHZ,
  parameter logic [7:0]  DEBOUNCE_MS = 8'd10,
  parameter logic [15:0] LONG_MS     = 16'd1000
) (
  input  logic CLOCK,
  input  logic RST_n,
  input  logic H2L_Sig,
  input  logic L2H_Sig,
  input  logic Pin_In,
  output logic Press_Pulse,
  output logic Release_Pulse,
  output logic Long_Pulse,
  output logic Key_State
);
  state_t      state_q, state_d;
  logic [1:0]  pin_sync_q;
  logic [7:0]  ms_q, ms_d;
  logic [15:0] hold_q, hold_d;
  logic        press_q, press_d, release_q, release_d, long_q, long_d, key_q, key_d;
  logic        tick, expire, lock_entry, in_lock, pin;

  ms_tick_gen #(.T1MS(T1MS)) u_tick (
    .clk  (CLOCK),
    .rst_n(RST_n),
    .clr  (lock_entry),
    .tick (tick)
  );

  assign pin = pin_sync_q[1];

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    expire    = tick && ms_q == DEBOUNCE_MS - 8'd1;
    case (state_q)
      IDLE: if (H2L_Sig) begin
        state_d = PRESS_LOCK;
        press_d = 1'b1;
      end
      PRESS_LOCK: if (expire) begin
        state_d   = pin ? RELEASE_LOCK : PRESSED;
        release_d = pin;
      end
      PRESSED: if (L2H_Sig) begin
        state_d   = RELEASE_LOCK;
        release_d = 1'b1;
      end
      RELEASE_LOCK: if (expire) begin
        state_d = pin ? IDLE : PRESS_LOCK;
        press_d = !pin;
      end
    endcase
    in_lock    = state_q == PRESS_LOCK || state_q == RELEASE_LOCK;
    lock_entry = state_d != state_q && (state_d == PRESS_LOCK || state_d == RELEASE_LOCK);
    ms_d       = lock_entry ? 8'd0 : (in_lock && tick) ? ms_q + 8'd1 : ms_q;
    // Hold time spans the press lockout too, so counting starts at press-lock entry
    hold_d     = (lock_entry && state_d == PRESS_LOCK) ? 16'd0 :
                 (tick && (state_q == PRESS_LOCK || state_q == PRESSED) && hold_q != 16'hFFFF) ?
                 hold_q + 16'd1 : hold_q;
    long_d     = state_q == PRESSED && state_d == PRESSED && tick && hold_q == LONG_MS - 16'd1;
    key_d      = state_d == PRESS_LOCK || state_d == PRESSED;
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      pin_sync_q <= 2'b11;
      ms_q       <= 8'd0;
      hold_q     <= 16'd0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      key_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pin_sync_q <= {pin_sync_q[0], Pin_In};
      ms_q       <= ms_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      key_q      <= key_d;
    end
  end

  assign Press_Pulse   = press_q;
  assign Release_Pulse = release_q;
  assign Long_Pulse    = long_q;
  assign Key_State     = key_q;
endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb_key_debounce_ctrl: directed and random key activity; a timing model predicts each
// output event with its cycle, and a negedge monitor pops and compares DUT events.
module tb_key_debounce_ctrl;
  localparam int P  = 10;
  localparam int D  = 3 * P;
  localparam int LP = 5 * P;
  localparam int M_IDLE = 0, M_PL = 1, M_PR = 2, M_RL = 3;

  typedef struct {
    int         cyc;
    logic [2:0] p;
    logic       k;
  } ev_t;

  logic clk = 1'b0, RST_n = 1'b0, H2L_Sig = 1'b0, L2H_Sig = 1'b0, Pin_In = 1'b1;
  logic Press_Pulse, Release_Pulse, Long_Pulse, Key_State;
  logic pin_h [0:40000];
  ev_t  q[$];
  ev_t  mon_e;
  int   cyc = 0, checks = 0, passed = 0;
  int   mode = M_IDLE, entry = 0, start = 0;
  logic prev_key = 1'b0;

  key_debounce_ctrl #(.T1MS(16'd9), .DEBOUNCE_MS(8'd3), .LONG_MS(16'd5)) dut (
    .CLOCK        (clk),
    .RST_n        (RST_n),
    .H2L_Sig      (H2L_Sig),
    .L2H_Sig      (L2H_Sig),
    .Pin_In       (Pin_In),
    .Press_Pulse  (Press_Pulse),
    .Release_Pulse(Release_Pulse),
    .Long_Pulse   (Long_Pulse),
    .Key_State    (Key_State)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input logic [2:0] p, input logic k);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.k   = k;
    q.push_back(e);
  endtask

  // Reference: lock expiry and long-press times are absolute cycle numbers derived from entry cycles
  task automatic model_step(input int n, input logic h, input logic l, input logic p);
    case (mode)
      M_IDLE: if (h) begin
        mode = M_PL; entry = n + 1; start = n + 1; push(n + 1, 3'b100, 1'b1);
      end
      M_PL: if (n == entry + D - 1) begin
        if (p) begin mode = M_RL; entry = n + 1; push(n + 1, 3'b010, 1'b0); end
        else mode = M_PR;
      end
      M_PR: if (l) begin
        mode = M_RL; entry = n + 1; push(n + 1, 3'b010, 1'b0);
      end else if (n + 1 == start + LP) push(n + 1, 3'b001, 1'b1);
      default: if (n == entry + D - 1) begin
        if (!p) begin mode = M_PL; entry = n + 1; start = n + 1; push(n + 1, 3'b100, 1'b1); end
        else mode = M_IDLE;
      end
    endcase
  endtask

  task automatic drive(input logic h, input logic l, input logic p);
    @(posedge clk);
    #1;
    cyc++;
    RST_n   = 1'b1;
    H2L_Sig = h;
    L2H_Sig = l;
    Pin_In  = p;
    pin_h[cyc] = p;
    model_step(cyc, h, l, pin_h[cyc-2]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      RST_n   = 1'b0;
      H2L_Sig = 1'b0;
      L2H_Sig = 1'b0;
      pin_h[cyc] = 1'b1;
      if (i == 0) begin
        #1;
        checks++;
        if ({Press_Pulse, Release_Pulse, Long_Pulse, Key_State} !== 4'b0000)
          $display("FAIL reset_outputs cyc=%0d got %b required 0000", cyc,
                   {Press_Pulse, Release_Pulse, Long_Pulse, Key_State});
        else passed++;
      end
    end
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        $display("FAIL missed_event cyc=%0d got nothing required p=%b k=%b", mon_e.cyc, mon_e.p, mon_e.k);
      end
    end
    mode = M_IDLE;
  endtask

  always @(negedge clk) begin
    if (!RST_n) prev_key = 1'b0;
    else begin
      if ({Press_Pulse, Release_Pulse, Long_Pulse} != 3'b000 || Key_State != prev_key) begin
        checks++;
        if (q.size() == 0)
          $display("FAIL unexpected_event cyc=%0d got p=%b k=%b required none", cyc,
                   {Press_Pulse, Release_Pulse, Long_Pulse}, Key_State);
        else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cyc || mon_e.p !== {Press_Pulse, Release_Pulse, Long_Pulse} || mon_e.k !== Key_State)
            $display("FAIL event cyc=%0d got p=%b k=%b required cyc=%0d p=%b k=%b", cyc,
                     {Press_Pulse, Release_Pulse, Long_Pulse}, Key_State, mon_e.cyc, mon_e.p, mon_e.k);
          else passed++;
        end
      end
      prev_key = Key_State;
    end
  end

  initial begin
    logic pin, flip, h, l;
    int   rate;
    for (int i = 0; i <= 40000; i++) pin_h[i] = 1'b1;
    do_reset(3);
    repeat (5) drive(0, 0, 1);
    // clean press held long enough for a long-press, then release
    drive(1, 0, 0);
    repeat (99) drive(0, 0, 0);
    drive(0, 1, 1);
    repeat (80) drive(0, 0, 1);
    // bounce during press lockout, settling low
    drive(1, 0, 0);
    repeat (4) drive(0, 0, 0);
    for (int i = 0; i < 10; i++) drive(i % 2 == 1, i % 2 == 0, i % 2 == 0);
    repeat (40) drive(0, 0, 0);
    drive(0, 1, 1);
    repeat (40) drive(0, 0, 1);
    // release edge swallowed by the lockout
    drive(1, 0, 0);
    repeat (9) drive(0, 0, 0);
    drive(0, 1, 1);
    repeat (80) drive(0, 0, 1);
    // both edges at once in IDLE and in PRESSED
    drive(1, 1, 0);
    repeat (40) drive(0, 0, 0);
    drive(1, 1, 1);
    repeat (40) drive(0, 0, 1);
    // reset in the middle of a press lockout
    drive(1, 0, 0);
    repeat (9) drive(0, 0, 0);
    do_reset(3);
    drive(1, 0, 0);
    repeat (40) drive(0, 0, 0);
    drive(0, 1, 1);
    repeat (40) drive(0, 0, 1);
    pin = 1'b1;
    for (int s = 0; s < 60; s++) begin
      rate = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
      for (int i = 0; i < 200; i++) begin
        flip = $urandom_range(0, 999) < rate;
        if (flip) pin = ~pin;
        h = (flip && !pin) || $urandom_range(0, 199) == 0;
        l = (flip && pin) || $urandom_range(0, 199) == 0;
        drive(h, l, pin);
      end
    end
    repeat (100) drive(0, 0, 1);
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      $display("FAIL missed_event cyc=%0d got nothing required p=%b k=%b", mon_e.cyc, mon_e.p, mon_e.k);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
